axi_ram_slave: RTL and testbench

AXI4 responder with on-chip RAM that answers the system's DDR master port: the cache-side AXI4 master writes and reads bursts through it. It is used in simulation and in FPGA builds without the MIG. It has independent read and write channel engines around a dual-port, byte-writable RAM. Each engine supports one outstanding INCR burst at full bus width.

---
 rtl/axi_ram_slave.sv | 194 +++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// AXI4 INCR-burst responder over a dual-port byte-writable RAM; independent read/write engines, one burst each.
// Latency: read beat 0 one cycle after AR; writes one beat per cycle; bvalid the cycle after the last beat. Backpressure: valid/data held until handshake.
module axi_ram_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int MEM_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [DATA_W-1:0]     axi_wdata,
    input  logic [DATA_W/8-1:0]   axi_wstrb,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic [ADDR_W-1:0]     axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [DATA_W-1:0]     axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int B      = $clog2(STRB_W);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    logic [DATA_W-1:0] mem [2**MEM_W];

    // Holds the address-ready outputs low for the cycle following a reset edge.
    logic              out_en_q;

    w_state_e          w_state_q, w_state_d;
    logic [MEM_W-1:0]  w_idx_q, w_idx_d;
    logic [7:0]        w_len_q, w_len_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              w_err_q, w_err_d;
    logic              w_en;

    r_state_e          r_state_q, r_state_d;
    logic [MEM_W-1:0]  r_idx_q, r_idx_d;
    logic [7:0]        r_len_q, r_len_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic [MEM_W-1:0]  r_rd_idx;
    logic              r_rd_en;
    logic [DATA_W-1:0] rdata_q;

    logic unused_addr;
    assign unused_addr = ^{axi_awaddr, axi_araddr};

    always_comb begin
        w_state_d   = w_state_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_err_d     = w_err_q;
        w_en        = 1'b0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_bresp   = 2'b00;
        case (w_state_q)
            W_IDLE: begin
                axi_awready = out_en_q;
                if (axi_awvalid && out_en_q) begin
                    w_idx_d   = axi_awaddr[MEM_W+B-1:B];
                    w_len_d   = axi_awlen;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                axi_wready = 1'b1;
                if (axi_wvalid) begin
                    w_en = 1'b1;
                    if (axi_wlast != (w_cnt_q == w_len_q)) begin
                        w_err_d = 1'b1;
                    end
                    // Burst length comes from awlen alone; a misplaced wlast only flags the error.
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_idx_d = w_idx_q + MEM_W'(1);
                        w_cnt_d = w_cnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                axi_bvalid = 1'b1;
                axi_bresp  = w_err_q ? 2'b10 : 2'b00;
                if (axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d   = r_state_q;
        r_idx_d     = r_idx_q;
        r_len_d     = r_len_q;
        r_cnt_d     = r_cnt_q;
        r_rd_idx    = r_idx_q;
        r_rd_en     = 1'b0;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                axi_arready = out_en_q;
                if (axi_arvalid && out_en_q) begin
                    r_rd_idx  = axi_araddr[MEM_W+B-1:B];
                    r_rd_en   = 1'b1;
                    r_idx_d   = r_rd_idx;
                    r_len_d   = axi_arlen;
                    r_cnt_d   = 8'd0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                axi_rvalid = 1'b1;
                axi_rlast  = (r_cnt_q == r_len_q);
                if (axi_rready) begin
                    if (axi_rlast) begin
                        r_state_d = R_IDLE;
                    end else begin
                        // Prefetch the next beat on the handshake so rdata only moves when consumed.
                        r_rd_idx = r_idx_q + MEM_W'(1);
                        r_rd_en  = 1'b1;
                        r_idx_d  = r_rd_idx;
                        r_cnt_d  = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        out_en_q <= !rst;
        if (rst) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            if (r_rd_en) begin
                rdata_q <= mem[r_rd_idx];
            end
        end
    end

    // RAM is never cleared; a same-cycle read of the written word sees the old value.
    always_ff @(posedge clk) begin
        if (w_en && !rst) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi_wstrb[i]) begin
                    mem[w_idx_q][i*8 +: 8] <= axi_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign axi_rdata = rdata_q;
    assign axi_rresp = 2'b00;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: directed scenarios plus randomized bursts against a word-array reference model.
module tb_axi_ram_slave;
    localparam int DW = 256;
    localparam int SW = 32;
    localparam int DEPTH = 65536;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]   axi_awaddr, axi_araddr;
    logic [7:0]    axi_awlen, axi_arlen;
    logic          axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic [DW-1:0] axi_wdata, axi_rdata;
    logic [SW-1:0] axi_wstrb;
    logic [1:0]    axi_bresp, axi_rresp;
    logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic          axi_rlast, axi_rvalid, axi_rready;

    axi_ram_slave dut (
        .clk(clk), .rst(rst),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem_m [int];
    logic [DW-1:0] wbeat [256];
    logic [SW-1:0] wstrbv [256];
    logic          wlastv [256];
    logic [DW-1:0] rbeat [256];
    logic          rlastv [256];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 5) & 32'h0000_FFFF);
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [DW-1:0] model_rd(input int i);
        return mem_m.exists(i) ? mem_m[i] : '0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len);
        for (int k = 0; k <= len; k++) begin
            int i = (widx(addr) + k) % DEPTH;
            logic [DW-1:0] w = model_rd(i);
            for (int b = 0; b < SW; b++)
                if (wstrbv[k][b]) w[b*8 +: 8] = wbeat[k][b*8 +: 8];
            mem_m[i] = w;
        end
    endtask

    task automatic fill_beats(input int len, input bit rnd_strb);
        for (int k = 0; k <= len; k++) begin
            wbeat[k]  = rnd_word();
            wstrbv[k] = rnd_strb ? $urandom : '1;
            wlastv[k] = (k == len);
        end
    endtask

    // Drives one write burst from wbeat/wstrbv/wlastv and reports what the DUT did.
    task automatic do_write(input logic [31:0] addr, input int len, output logic [1:0] bresp,
                            output bit early_b, output bit late_b, output bit to);
        int guard;
        to = 0; early_b = 0; late_b = 0; bresp = 2'b11;
        @(negedge clk);
        axi_awaddr = addr; axi_awlen = 8'(len); axi_awvalid = 1'b1;
        guard = 0;
        while (!axi_awready && guard < 100) begin @(negedge clk); guard++; end
        if (!axi_awready) begin to = 1; axi_awvalid = 1'b0; return; end
        @(negedge clk);
        axi_awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            axi_wdata = wbeat[k]; axi_wstrb = wstrbv[k]; axi_wlast = wlastv[k]; axi_wvalid = 1'b1;
            if (axi_bvalid) early_b = 1;
            guard = 0;
            while (!axi_wready && guard < 100) begin @(negedge clk); guard++; end
            if (!axi_wready) begin to = 1; axi_wvalid = 1'b0; return; end
            @(negedge clk);
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        if (!axi_bvalid) late_b = 1;
        guard = 0;
        while (!axi_bvalid && guard < 100) begin @(negedge clk); guard++; end
        if (!axi_bvalid) begin to = 1; return; end
        bresp = axi_bresp;
        axi_bready = 1'b1;
        @(negedge clk);
        axi_bready = 1'b0;
        model_write(addr, len);
    endtask

    // Drives one read burst with rready held high; beats land in rbeat/rlastv.
    task automatic do_read(input logic [31:0] addr, input int len, output int n, output bit lat_ok,
                           output bit gap, output bit ar_hi, output bit post_rv, output bit post_ar,
                           output bit to);
        int guard;
        n = 0; lat_ok = 0; gap = 0; ar_hi = 0; post_rv = 0; post_ar = 0; to = 0;
        @(negedge clk);
        axi_araddr = addr; axi_arlen = 8'(len); axi_arvalid = 1'b1;
        guard = 0;
        while (!axi_arready && guard < 100) begin @(negedge clk); guard++; end
        if (!axi_arready) begin to = 1; axi_arvalid = 1'b0; return; end
        @(negedge clk);
        axi_arvalid = 1'b0; axi_rready = 1'b1;
        lat_ok = axi_rvalid;
        guard = 0;
        while (n <= len && guard < 1000) begin
            if (axi_rvalid) begin rbeat[n] = axi_rdata; rlastv[n] = axi_rlast; n++; end
            else gap = 1;
            if (axi_arready) ar_hi = 1;
            @(negedge clk); guard++;
        end
        axi_rready = 1'b0;
        post_rv = axi_rvalid; post_ar = axi_arready;
        if (n <= len) to = 1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 0; axi_wdata = '0; axi_wstrb = '0;
        axi_wlast = 0; axi_wvalid = 0; axi_bready = 0; axi_araddr = '0; axi_arlen = '0;
        axi_arvalid = 0; axi_rready = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000", {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast});
        end
        checks++;
        if ({axi_bresp, axi_rresp} !== 4'b0 || axi_rdata !== '0) begin
            failures++;
            $display("FAIL reset_data bresp=%b rresp=%b rdata=%h want zeros", axi_bresp, axi_rresp, axi_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({axi_awready, axi_arready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_release aw/ar ready got=%b want=11", {axi_awready, axi_arready});
        end
    endtask

    task automatic test_basic;
        logic [1:0] br; bit eb, lb, to, lat, gap, arh, prv, par; int n;
        for (int k = 0; k < 4; k++) begin
            wbeat[k] = {248'd0, 8'(8'hA0 + k)}; wstrbv[k] = '1; wlastv[k] = (k == 3);
        end
        do_write(32'h40, 3, br, eb, lb, to);
        checks++;
        if (to || eb || lb || br !== 2'b00) begin
            failures++;
            $display("FAIL basic_write to=%0d early=%0d late=%0d bresp=%b want 0/0/0/00", to, eb, lb, br);
        end
        do_read(32'h40, 3, n, lat, gap, arh, prv, par, to);
        checks++;
        if (to || !lat || gap || arh || prv || !par) begin
            failures++;
            $display("FAIL basic_read_timing to=%0d lat=%0d gap=%0d ar_hi=%0d post_rv=%0d post_ar=%0d want 0/1/0/0/0/1",
                     to, lat, gap, arh, prv, par);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rbeat[k] !== {248'd0, 8'(8'hA0 + k)} || rlastv[k] !== (k == 3)) begin
                failures++;
                $display("FAIL basic_beat%0d got=%h last=%0d want=%h last=%0d", k, rbeat[k], rlastv[k], 8'(8'hA0 + k), (k == 3));
            end
        end
    endtask

    task automatic test_strobe;
        logic [1:0] br; bit eb, lb, to, lat, gap, arh, prv, par; int n;
        wbeat[0] = '1; wstrbv[0] = '1; wlastv[0] = 1'b1;
        do_write(32'h200, 0, br, eb, lb, to);
        wbeat[0] = '0; wstrbv[0] = 32'h1;
        do_write(32'h200, 0, br, eb, lb, to);
        do_read(32'h200, 0, n, lat, gap, arh, prv, par, to);
        checks++;
        if (to || rbeat[0] !== ~256'hFF || rlastv[0] !== 1'b1) begin
            failures++;
            $display("FAIL strobe got=%h last=%0d want byte0=00 rest=FF last=1", rbeat[0], rlastv[0]);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] br; bit eb, lb, to, stalled, arh;
        logic [DW-1:0] prev_d; logic prev_l; int n, cyc;
        fill_beats(3, 0);
        do_write(32'h1000, 3, br, eb, lb, to);
        @(negedge clk);
        axi_araddr = 32'h1000; axi_arlen = 8'd3; axi_arvalid = 1'b1;
        cyc = 0;
        while (!axi_arready && cyc < 100) begin @(negedge clk); cyc++; end
        @(negedge clk);
        axi_arvalid = 1'b0;
        n = 0; cyc = 0; stalled = 0; arh = 0; prev_d = '0; prev_l = 0;
        while (n < 4 && cyc < 100) begin
            if (stalled) begin
                checks++;
                if (axi_rdata !== prev_d || axi_rlast !== prev_l || !axi_rvalid) begin
                    failures++;
                    $display("FAIL bp_stable cyc=%0d got=%h last=%0d want=%h last=%0d", cyc, axi_rdata, axi_rlast, prev_d, prev_l);
                end
            end
            if (axi_arready) arh = 1;
            axi_rready = (cyc % 3 == 0);
            if (axi_rvalid && axi_rready) begin
                checks++;
                if (axi_rdata !== model_rd(widx(32'h1000) + n) || axi_rlast !== (n == 3)) begin
                    failures++;
                    $display("FAIL bp_beat%0d got=%h last=%0d want=%h last=%0d", n, axi_rdata, axi_rlast,
                             model_rd(widx(32'h1000) + n), (n == 3));
                end
                n++; stalled = 0;
            end else begin
                stalled = axi_rvalid; prev_d = axi_rdata; prev_l = axi_rlast;
            end
            @(negedge clk); cyc++;
        end
        axi_rready = 1'b0;
        checks++;
        if (n != 4 || arh || axi_rvalid || !axi_arready) begin
            failures++;
            $display("FAIL bp_end beats=%0d ar_hi=%0d rvalid=%0d arready=%0d want 4/0/0/1", n, arh, axi_rvalid, axi_arready);
        end
    endtask

    task automatic test_wlast_err;
        logic [1:0] br; bit eb, lb, to, lat, gap, arh, prv, par; int n;
        fill_beats(3, 0);
        for (int k = 0; k < 4; k++) wlastv[k] = (k == 1);
        do_write(32'h2000, 3, br, eb, lb, to);
        checks++;
        if (to || eb || lb || br !== 2'b10) begin
            failures++;
            $display("FAIL wlast_err to=%0d early=%0d late=%0d bresp=%b want 0/0/0/10", to, eb, lb, br);
        end
        fill_beats(3, 0);
        do_write(32'h2000, 3, br, eb, lb, to);
        checks++;
        if (to || br !== 2'b00) begin
            failures++;
            $display("FAIL wlast_recover to=%0d bresp=%b want 0/00", to, br);
        end
        do_read(32'h2000, 3, n, lat, gap, arh, prv, par, to);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rbeat[k] !== model_rd(widx(32'h2000) + k)) begin
                failures++;
                $display("FAIL wlast_data%0d got=%h want=%h", k, rbeat[k], model_rd(widx(32'h2000) + k));
            end
        end
    endtask

    task automatic test_wrap;
        logic [1:0] br; bit eb, lb, to, lat, gap, arh, prv, par; int n;
        logic [DW-1:0] w0, w1;
        fill_beats(1, 0);
        w0 = wbeat[0]; w1 = wbeat[1];
        do_write(32'hA01F_FFE0, 1, br, eb, lb, to);
        checks++;
        if (to || br !== 2'b00) begin
            failures++;
            $display("FAIL wrap_write to=%0d bresp=%b want 0/00", to, br);
        end
        do_read(32'h0000_0000, 0, n, lat, gap, arh, prv, par, to);
        checks++;
        if (to || rbeat[0] !== w1) begin
            failures++;
            $display("FAIL wrap_idx0 got=%h want=%h", rbeat[0], w1);
        end
        do_read(32'h001F_FFE0, 1, n, lat, gap, arh, prv, par, to);
        checks++;
        if (to || rbeat[0] !== w0 || rbeat[1] !== w1 || rlastv[1] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_read got=%h,%h want=%h,%h", rbeat[0], rbeat[1], w0, w1);
        end
    endtask

    task automatic test_concurrent;
        logic [1:0] br; bit eb, lb, to, lat, gap, arh, prv, par; int n;
        logic [DW-1:0] oldv, newv;
        fill_beats(0, 0);
        oldv = wbeat[0];
        do_write(32'hA0, 0, br, eb, lb, to);
        newv = rnd_word();
        @(negedge clk);
        axi_awaddr = 32'hA0; axi_awlen = 8'd0; axi_awvalid = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0;
        axi_wdata = newv; axi_wstrb = '1; axi_wlast = 1'b1; axi_wvalid = 1'b1;
        axi_araddr = 32'hA0; axi_arlen = 8'd0; axi_arvalid = 1'b1;
        checks++;
        if (!axi_wready || !axi_arready) begin
            failures++;
            $display("FAIL conc_align wready=%0d arready=%0d want 1/1", axi_wready, axi_arready);
        end
        @(negedge clk);
        axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_arvalid = 1'b0;
        checks++;
        if (!axi_rvalid || axi_rdata !== oldv || !axi_rlast || !axi_bvalid || axi_bresp !== 2'b00) begin
            failures++;
            $display("FAIL conc_readfirst rvalid=%0d bvalid=%0d got=%h want=%h", axi_rvalid, axi_bvalid, axi_rdata, oldv);
        end
        axi_rready = 1'b1; axi_bready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0; axi_bready = 1'b0;
        mem_m[5] = newv;
        do_read(32'hA0, 0, n, lat, gap, arh, prv, par, to);
        checks++;
        if (to || rbeat[0] !== newv) begin
            failures++;
            $display("FAIL conc_after got=%h want=%h", rbeat[0], newv);
        end
    endtask

    task automatic test_reset_mid;
        logic [1:0] br; bit eb, lb, to, lat, gap, arh, prv, par; int n;
        fill_beats(3, 0);
        @(negedge clk);
        axi_awaddr = 32'h3000; axi_awlen = 8'd3; axi_awvalid = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            axi_wdata = wbeat[k]; axi_wstrb = '1; axi_wvalid = 1'b1;
            @(negedge clk);
        end
        axi_wvalid = 1'b0;
        model_write(32'h3000, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast, axi_bresp} !== 8'b0) begin
            failures++;
            $display("FAIL rstw_outs got=%b want=00000000", {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast, axi_bresp});
        end
        @(negedge clk);
        checks++;
        if ({axi_awready, axi_arready} !== 2'b11) begin
            failures++;
            $display("FAIL rstw_ready got=%b want=11", {axi_awready, axi_arready});
        end
        do_read(32'h3000, 1, n, lat, gap, arh, prv, par, to);
        checks++;
        if (to || rbeat[0] !== model_rd(widx(32'h3000)) || rbeat[1] !== model_rd(widx(32'h3000) + 1)) begin
            failures++;
            $display("FAIL rstw_partial got=%h,%h want=%h,%h", rbeat[0], rbeat[1], model_rd(widx(32'h3000)), model_rd(widx(32'h3000) + 1));
        end
        @(negedge clk);
        axi_araddr = 32'h3000; axi_arlen = 8'd1; axi_arvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0; axi_rready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({axi_arready, axi_rvalid, axi_rlast, axi_rresp} !== 5'b0 || axi_rdata !== '0) begin
            failures++;
            $display("FAIL rstr_outs ar=%0d rv=%0d rl=%0d rdata=%h want zeros", axi_arready, axi_rvalid, axi_rlast, axi_rdata);
        end
        @(negedge clk);
        checks++;
        if ({axi_awready, axi_arready} !== 2'b11) begin
            failures++;
            $display("FAIL rstr_ready got=%b want=11", {axi_awready, axi_arready});
        end
        fill_beats(3, 0);
        do_write(32'h3100, 3, br, eb, lb, to);
        do_read(32'h3100, 3, n, lat, gap, arh, prv, par, to);
        checks++;
        if (to || br !== 2'b00 || !lat || gap || rbeat[3] !== model_rd(widx(32'h3100) + 3) || !rlastv[3]) begin
            failures++;
            $display("FAIL rst_recover to=%0d bresp=%b got=%h want=%h", to, br, rbeat[3], model_rd(widx(32'h3100) + 3));
        end
    endtask

    task automatic test_long;
        logic [1:0] br; bit eb, lb, to, lat, gap, arh, prv, par; int n, bad;
        fill_beats(255, 0);
        do_write(32'h8000, 255, br, eb, lb, to);
        checks++;
        if (to || eb || lb || br !== 2'b00) begin
            failures++;
            $display("FAIL long_write to=%0d early=%0d late=%0d bresp=%b", to, eb, lb, br);
        end
        do_read(32'h8000, 255, n, lat, gap, arh, prv, par, to);
        bad = 0;
        for (int k = 0; k < 256; k++)
            if (rbeat[k] !== model_rd(widx(32'h8000) + k) || rlastv[k] !== (k == 255)) bad++;
        checks++;
        if (to || n != 256 || gap || bad != 0) begin
            failures++;
            $display("FAIL long_read to=%0d beats=%0d gap=%0d bad=%0d want 0/256/0/0", to, n, gap, bad);
        end
    endtask

    task automatic test_random;
        logic [1:0] br; bit eb, lb, to, lat, gap, arh, prv, par; int n, len, start;
        fill_beats(63, 0);
        do_write(32'(200 * 32), 63, br, eb, lb, to);
        for (int it = 0; it < 24; it++) begin
            len = $urandom_range(0, 15);
            start = $urandom_range(200, 248);
            if ($urandom_range(0, 1) == 1) begin
                fill_beats(len, 1);
                do_write(32'(start * 32) | 32'($urandom_range(0, 31)), len, br, eb, lb, to);
                checks++;
                if (to || br !== 2'b00) begin
                    failures++;
                    $display("FAIL rnd_write it=%0d to=%0d bresp=%b", it, to, br);
                end
            end else begin
                do_read(32'(start * 32), len, n, lat, gap, arh, prv, par, to);
                for (int k = 0; k <= len; k++) begin
                    checks++;
                    if (to || rbeat[k] !== model_rd(start + k) || rlastv[k] !== (k == len)) begin
                        failures++;
                        $display("FAIL rnd_read it=%0d beat=%0d got=%h want=%h", it, k, rbeat[k], model_rd(start + k));
                    end
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_backpressure();
        test_wlast_err();
        test_wrap();
        test_concurrent();
        test_reset_mid();
        test_long();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
